// File: rtl/seq_slt_cmp.sv
// Multi-cycle set-less-than unit: compares two operands MSB-first, DIGIT bits per clock,
// in signed or unsigned mode, with a start/busy/done handshake.
module seq_slt_cmp #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             lt,
  output logic             eq
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("seq_slt_cmp: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic {IDLE, CMP} state_t;

  state_t            state;
  logic [CW-1:0]     counter;
  logic              decided;
  logic              lt_acc;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic [WIDTH-1:0]  sign_mask;
  logic [DIGIT-1:0]  ca;
  logic [DIGIT-1:0]  cb;
  logic              dec_nxt;
  logic              lt_nxt;
  logic              last;
  logic              accept;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_mask = {signed_mode, {(WIDTH-1){1'b0}}};
  assign accept    = (state == IDLE) && start;

  assign ca      = a[WIDTH-1 -: DIGIT];
  assign cb      = b[WIDTH-1 -: DIGIT];
  assign dec_nxt = decided | (ca != cb);
  assign lt_nxt  = decided ? lt_acc : (ca < cb);
  assign last    = (counter == CW'(N - 1));

  // Operand shift registers carry no reset; they are only read while in CMP.
  always_ff @(posedge clk) begin
    if (accept) begin
      a <= i0 ^ sign_mask;
      b <= i1 ^ sign_mask;
    end else if (state == CMP) begin
      a <= a << DIGIT;
      b <= b << DIGIT;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      counter <= '0;
      decided <= 1'b0;
      lt_acc  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      lt      <= 1'b0;
      eq      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= CMP;
            counter <= '0;
            decided <= 1'b0;
            lt_acc  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        CMP: begin
          decided <= dec_nxt;
          lt_acc  <= lt_nxt;
          counter <= counter + 1'b1;
          // Fixed-length scan: no early exit, so latency is data-independent.
          if (last) begin
            lt      <= lt_nxt;
            eq      <= ~dec_nxt;
            result  <= {{(WIDTH-1){1'b0}}, lt_nxt};
            done    <= 1'b1;
            busy    <= 1'b0;
            counter <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
